// File: rtl/cachepkg.sv
// Shared types and constants for the line-memory model.
package cachepkg;

  localparam int LINEADDR_BITS = 26;
  localparam int BEATS = 16;

  typedef enum logic [1:0] {
    NOP       = 2'd0,
    READ_OUT  = 2'd1,
    WRITE_OUT = 2'd2
  } op_t;

endpackage

// File: rtl/lnext_store.sv
// Backing line array with per-line valid bits.
// One write port, one combinational read port.
module lnext_store #(
  parameter int DEPTH = 256,
  parameter int WORDS = 16,
  localparam int IW = $clog2(DEPTH),
  localparam int BW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [IW-1:0] wr_line,
  input  logic [BW-1:0] wr_beat,
  input  logic [31:0]   wr_data,
  input  logic          set_valid,
  input  logic          clr_valid,
  input  logic [IW-1:0] clr_line,
  input  logic [IW-1:0] rd_line,
  input  logic [BW-1:0] rd_beat,
  output logic [31:0]   rd_data,
  output logic          rd_valid
);

  logic [31:0]    r_mem [DEPTH*WORDS];
  logic [DEPTH-1:0] r_valid;

  // Data array is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (we)
      r_mem[{wr_line, wr_beat}] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      if (clr_valid)
        r_valid[clr_line] <= 1'b0;
      if (set_valid)
        r_valid[wr_line] <= 1'b1;
    end
  end

  assign rd_data  = r_mem[{rd_line, rd_beat}];
  assign rd_valid = r_valid[rd_line];

endmodule

// File: rtl/lnext_mem.sv
// Line-granular memory model: fixed-latency burst reads,
// burst writes, pattern data for never-written lines.
module lnext_mem
  import cachepkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256,
  parameter int BEATS   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  op_t                      req_op,
  input  logic [LINEADDR_BITS-1:0] req_addr,
  output logic                     req_ready,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic [3:0]               rsp_beat,
  output logic                     rsp_last,
  input  logic                     rsp_ready,
  output logic [31:0]              reads,
  output logic [31:0]              writes
);

  localparam int IW = $clog2(DEPTH);
  localparam int BW = $clog2(BEATS);
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_RECV
  } state_t;

  state_t                   r_state;
  logic [LINEADDR_BITS-1:0] r_addr;
  logic [3:0]               r_lat_cnt;
  logic [3:0]               r_beat_cnt;
  logic                     r_req_ready;
  logic                     r_wr_ready;
  logic                     r_rsp_valid;
  logic [31:0]              r_rsp_data;
  logic [3:0]               r_rsp_beat;
  logic                     r_rsp_last;
  logic [31:0]              r_reads;
  logic [31:0]              r_writes;

  logic        w_req_fire;
  logic        w_rsp_fire;
  logic        w_wr_fire;
  logic        w_we;
  logic        w_set_valid;
  logic        w_clr_valid;
  logic [3:0]  w_rd_beat;
  logic [31:0] w_st_data;
  logic        w_st_valid;
  logic [31:0] w_rd_word;

  assign w_req_fire = req_valid & r_req_ready;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign w_wr_fire  = wr_valid & r_wr_ready;

  assign w_we        = (r_state == S_RECV) & w_wr_fire;
  assign w_set_valid = w_we & (r_beat_cnt == LAST_BEAT);
  // A new write invalidates the line until its last beat lands.
  assign w_clr_valid = w_req_fire & (req_op == WRITE_OUT);

  // Read port looks one beat ahead so rsp_data can be registered.
  assign w_rd_beat = (r_state == S_WAIT) ? 4'd0 : r_beat_cnt + 4'd1;
  assign w_rd_word = w_st_valid ? w_st_data
                                : {r_addr, w_rd_beat, 2'b00};

  lnext_store #(
    .DEPTH(DEPTH),
    .WORDS(BEATS)
  ) u_store (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (w_we),
    .wr_line  (r_addr[IW-1:0]),
    .wr_beat  (r_beat_cnt[BW-1:0]),
    .wr_data  (wr_data),
    .set_valid(w_set_valid),
    .clr_valid(w_clr_valid),
    .clr_line (req_addr[IW-1:0]),
    .rd_line  (r_addr[IW-1:0]),
    .rd_beat  (w_rd_beat[BW-1:0]),
    .rd_data  (w_st_data),
    .rd_valid (w_st_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_lat_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_beat  <= '0;
      r_rsp_last  <= 1'b0;
      r_reads     <= '0;
      r_writes    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            case (req_op)
              READ_OUT: begin
                r_addr      <= req_addr;
                r_lat_cnt   <= 4'(LATENCY);
                r_state     <= S_WAIT;
                r_req_ready <= 1'b0;
                if (r_reads != 32'hFFFF_FFFF)
                  r_reads <= r_reads + 32'd1;
              end
              WRITE_OUT: begin
                r_addr      <= req_addr;
                r_beat_cnt  <= '0;
                r_state     <= S_RECV;
                r_req_ready <= 1'b0;
                r_wr_ready  <= 1'b1;
                if (r_writes != 32'hFFFF_FFFF)
                  r_writes <= r_writes + 32'd1;
              end
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == 4'd0) begin
            r_state     <= S_SEND;
            r_beat_cnt  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_word;
            r_rsp_beat  <= '0;
            r_rsp_last  <= (LAST_BEAT == 4'd0);
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_SEND: begin
          if (w_rsp_fire) begin
            if (r_rsp_last) begin
              r_state     <= S_IDLE;
              r_rsp_valid <= 1'b0;
              r_rsp_last  <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_beat_cnt <= w_rd_beat;
              r_rsp_beat <= w_rd_beat;
              r_rsp_data <= w_rd_word;
              r_rsp_last <= (w_rd_beat == LAST_BEAT);
            end
          end
        end
        S_RECV: begin
          if (w_wr_fire) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state     <= S_IDLE;
              r_wr_ready  <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_beat  = r_rsp_beat;
  assign rsp_last  = r_rsp_last;
  assign reads     = r_reads;
  assign writes    = r_writes;

endmodule

// File: tb/tb_lnext_mem.sv
// Scoreboard bench for lnext_mem: reads, writes,
// backpressure, back-to-back, NOP and mid-write reset.
module tb_lnext_mem;
  import cachepkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  op_t         req_op = NOP;
  logic [25:0] req_addr = '0;
  logic        req_ready;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_beat;
  logic        rsp_last;
  logic        rsp_ready = 1'b0;
  logic [31:0] reads;
  logic [31:0] writes;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  bit          mvalid[256];
  logic [31:0] mdata[4096];

  lnext_mem dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_beat (rsp_beat),
    .rsp_last (rsp_last),
    .rsp_ready(rsp_ready),
    .reads    (reads),
    .writes   (writes)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_word(
    input logic [25:0] a, input int b);
    logic [7:0] idx;
    logic [3:0] bb;
    idx = a[7:0];
    bb  = 4'(b);
    if (mvalid[idx])
      return mdata[{idx, bb}];
    return {a, bb, 2'b00};
  endfunction

  task automatic push_line(input logic [25:0] a);
    for (int b = 0; b < 16; b++)
      q.push_back(exp_word(a, b));
  endtask

  task automatic accept_req(input op_t op,
                            input logic [25:0] a,
                            input bit keep);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    @(posedge clock); #1;
    if (!keep) begin
      req_valid = 1'b0;
      req_op    = NOP;
    end
  endtask

  // Called #1 after the acceptance edge; mode 1 = ready 1,0,0,1.
  task automatic drain(input int mode, input int exp_lat);
    int k = 0;
    int got = 0;
    int first = -1;
    bit stalled = 0;
    bit rq_bad = 0;
    bit ex_bad = 0;
    logic [31:0] sd = '0;
    logic [3:0]  sb = '0;
    logic [31:0] e;
    while (got < 16 && k < 400) begin
      rsp_ready = (mode == 0) ? 1'b1 :
                  ((k % 4 == 0) || (k % 4 == 3));
      if (req_ready) rq_bad = 1;
      if (rsp_valid && wr_ready) ex_bad = 1;
      if (rsp_valid) begin
        if (first < 0) first = k;
        if (stalled) begin
          checks++;
          if (rsp_data !== sd || rsp_beat !== sb) begin
            errors++;
            $display("FAIL stall_hold: got %h/%0d want %h/%0d",
                     rsp_data, rsp_beat, sd, sb);
          end
        end
        if (rsp_ready) begin
          e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
          checks++;
          if (rsp_data !== e) begin
            errors++;
            $display("FAIL rsp_data beat %0d: got %h want %h",
                     got, rsp_data, e);
          end
          checks++;
          if (rsp_beat !== 4'(got)) begin
            errors++;
            $display("FAIL rsp_beat: got %0d want %0d",
                     rsp_beat, got);
          end
          checks++;
          if (rsp_last !== (got == 15)) begin
            errors++;
            $display("FAIL rsp_last beat %0d: got %b want %b",
                     got, rsp_last, (got == 15));
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          sd = rsp_data;
          sb = rsp_beat;
        end
      end
      @(posedge clock); #1;
      k++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL beat_count: got %0d want 16", got);
    end
    checks++;
    if (rq_bad) begin
      errors++;
      $display("FAIL req_ready_busy: got 1 want 0");
    end
    checks++;
    if (ex_bad) begin
      errors++;
      $display("FAIL exclusive: rsp_valid and wr_ready both 1");
    end
    if (exp_lat >= 0) begin
      checks++;
      if (first != exp_lat) begin
        errors++;
        $display("FAIL latency: got %0d want %0d",
                 first, exp_lat);
      end
    end
  endtask

  task automatic write_beats(input logic [25:0] a,
                             input int n,
                             input logic [31:0] base);
    int t;
    logic [7:0] idx;
    idx = a[7:0];
    accept_req(WRITE_OUT, a, 0);
    mvalid[idx] = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      t = 0;
      while (!wr_ready && t < 50) begin
        @(posedge clock); #1;
        t++;
      end
      if (t == 50) begin
        errors++;
        checks++;
        $display("FAIL wr_ready_timeout: got 0 want 1");
      end
      mdata[{idx, 4'(i)}] = base + 32'(i);
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    if (n == 16) mvalid[idx] = 1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) mvalid[i] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_ready: got %b want 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_valids: got %b%b want 00",
               rsp_valid, wr_ready);
    end
    checks++;
    if (reads !== 0 || writes !== 0) begin
      errors++;
      $display("FAIL rst_counts: got %0d/%0d want 0/0",
               reads, writes);
    end
    checks++;
    if (rsp_data !== 0 || rsp_beat !== 0 || rsp_last !== 0) begin
      errors++;
      $display("FAIL rst_rsp: got %h/%0d/%b want 0/0/0",
               rsp_data, rsp_beat, rsp_last);
    end
  endtask

  task automatic test_read_pattern();
    accept_req(READ_OUT, 26'h0000123, 0);
    push_line(26'h0000123);
    drain(0, 5);
    checks++;
    if (reads !== 32'd1) begin
      errors++;
      $display("FAIL reads_1: got %0d want 1", reads);
    end
  endtask

  task automatic test_write_read();
    write_beats(26'h0000005, 16, 32'hA000_0000);
    checks++;
    if (writes !== 32'd1) begin
      errors++;
      $display("FAIL writes_1: got %0d want 1", writes);
    end
    accept_req(READ_OUT, 26'h0000005, 0);
    push_line(26'h0000005);
    drain(0, 5);
  endtask

  task automatic test_backpressure();
    accept_req(READ_OUT, 26'h0000005, 0);
    push_line(26'h0000005);
    drain(1, -1);
    accept_req(READ_OUT, 26'h0000077, 0);
    push_line(26'h0000077);
    drain(1, -1);
  endtask

  task automatic test_alias();
    accept_req(READ_OUT, 26'h0ABC105, 0);
    push_line(26'h0ABC105);
    drain(0, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0;
    r0 = reads;
    accept_req(READ_OUT, 26'h0000040, 1);
    push_line(26'h0000040);
    drain(0, 5);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_op    = NOP;
    checks++;
    if (reads !== r0 + 32'd2) begin
      errors++;
      $display("FAIL b2b_reads: got %0d want %0d",
               reads, r0 + 32'd2);
    end
    push_line(26'h0000040);
    drain(0, 5);
  endtask

  task automatic test_nop();
    logic [31:0] r0, w0;
    r0 = reads;
    w0 = writes;
    req_valid = 1'b1;
    req_addr  = 26'h0000005;
    wr_valid  = 1'b1;
    wr_data   = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      req_op = (i < 2) ? NOP : op_t'(2'b11);
      @(posedge clock); #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
          wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL nop_state: got %b%b%b want 100",
                 req_ready, rsp_valid, wr_ready);
      end
    end
    req_valid = 1'b0;
    req_op    = NOP;
    wr_valid  = 1'b0;
    checks++;
    if (reads !== r0 || writes !== w0) begin
      errors++;
      $display("FAIL nop_counts: got %0d/%0d want %0d/%0d",
               reads, writes, r0, w0);
    end
    accept_req(READ_OUT, 26'h0000005, 0);
    push_line(26'h0000005);
    drain(0, 5);
  endtask

  task automatic test_reset_mid_write();
    write_beats(26'h0000009, 7, 32'hC000_0000);
    wr_valid = 1'b1;
    wr_data  = 32'hC000_0007;
    do_reset();
    checks++;
    if (reads !== 0 || writes !== 0 || wr_ready !== 1'b0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got %0d/%0d/%b/%b want 0/0/0/1",
               reads, writes, wr_ready, req_ready);
    end
    accept_req(READ_OUT, 26'h0000009, 0);
    push_line(26'h0000009);
    drain(0, 5);
    accept_req(READ_OUT, 26'h0000005, 0);
    push_line(26'h0000005);
    drain(0, 5);
  endtask

  initial begin
    test_reset();
    test_read_pattern();
    test_write_read();
    test_backpressure();
    test_alias();
    test_back_to_back();
    test_nop();
    test_reset_mid_write();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
